sha256_msg_padder: RTL and testbench

- Upstream feeder for the SHA-256 core. Accepts a raw byte-message stream from the host as 32-bit words, applies SHA-256 padding (0x80 marker, zero fill, 64-bit big-endian bit length) and emits 16-word chunks on the core's word-load interface.
- Paces chunks by waiting for the core's finish pulse before starting the next chunk.
- Sits between the AXI/DMA host side and the core; the hash outputs are read directly from the core.

---
 rtl/sha256_msg_padder.sv | 168 ++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: takes a host byte stream packed in 32-bit words and applies
// SHA-256 padding: a 0x80 marker, zero fill, then the 64-bit big-endian bit length.
// It emits 16-word chunks to the core and waits for the core's finish pulse
// before it starts the next chunk.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   s_valid/s_ready        host handshake; s_data (first byte in [7:0]), s_last, s_nbytes
//   dat_valid_o/dat_lsb_o  registered word strobe and word to the core
//   core_finish_i          core chunk-done pulse
//   busy_o                 message in progress
//   msg_done_o             one-cycle pulse once the final chunk has been hashed
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [2:0]  s_nbytes,
  output logic        dat_valid_o,
  output logic [31:0] dat_lsb_o,
  input  logic        core_finish_i,
  output logic        busy_o,
  output logic        msg_done_o
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WIDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_MARK, S_ZERO, S_LEN_HI, S_LEN_LO, S_WAIT, S_DONE
  } state_e;

  state_e              state_q, state_d, ret_q, ret_d, tgt;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [LEN_W-1:0]    bytes_q, bytes_d;
  logic                s_ready_q, s_ready_d;
  logic                dat_valid_q, dat_valid_d;
  logic [WORD_W-1:0]   dat_lsb_q, dat_lsb_d;
  logic                busy_q, busy_d;
  logic                msg_done_q, msg_done_d;
  logic                xfer;
  logic                emit;
  logic [WORD_W-1:0]   word;
  logic [63:0]         bitlen;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  assign xfer   = s_valid & s_ready_q;
  assign bitlen = 64'(bytes_q) << 3;

  // Next-state, word generation and registered-output computation
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    widx_d      = widx_q;
    bytes_d     = bytes_q;
    tgt         = state_q;
    emit        = 1'b0;
    word        = '0;

    case (state_q)
      S_IDLE, S_DATA: begin
        if (xfer) begin
          if (s_last) begin
            bytes_d = bytes_q + LEN_W'(s_nbytes);
            case (s_nbytes)
              3'd0: tgt = S_MARK;
              3'd1: begin emit = 1'b1; word = {16'h0, 8'h80, s_data[7:0]};  tgt = S_ZERO; end
              3'd2: begin emit = 1'b1; word = {8'h0, 8'h80, s_data[15:0]};  tgt = S_ZERO; end
              3'd3: begin emit = 1'b1; word = {8'h80, s_data[23:0]};        tgt = S_ZERO; end
              default: begin emit = 1'b1; word = s_data; tgt = S_MARK; end
            endcase
          end else begin
            bytes_d = bytes_q + LEN_W'(3'd4);
            emit    = 1'b1;
            word    = s_data;
            tgt     = S_DATA;
          end
        end
      end
      S_MARK: begin
        emit = 1'b1;
        word = 32'h0000_0080;
        tgt  = S_ZERO;
      end
      S_ZERO: begin
        // Word 14 is where the length starts; fill zeros until we get there
        if (widx_q == 4'd14) begin
          tgt = S_LEN_HI;
        end else begin
          emit = 1'b1;
          tgt  = (widx_q == 4'd13) ? S_LEN_HI : S_ZERO;
        end
      end
      S_LEN_HI: begin
        emit = 1'b1;
        word = bswap32(bitlen[63:32]);
        tgt  = S_LEN_LO;
      end
      S_LEN_LO: begin
        emit = 1'b1;
        word = bswap32(bitlen[31:0]);
        tgt  = S_DONE;
      end
      S_WAIT: begin
        if (core_finish_i) tgt = ret_q;
      end
      S_DONE: begin
        bytes_d = '0;
        tgt     = S_IDLE;
      end
      default: tgt = S_IDLE;
    endcase

    // A word that fills the chunk parks the FSM in WAIT; it resumes at the intended state
    state_d = tgt;
    if (emit) begin
      widx_d = widx_q + WIDX_W'(1);
      if (widx_q == 4'd15) begin
        state_d = S_WAIT;
        ret_d   = tgt;
      end
    end

    s_ready_d   = (state_d == S_IDLE) || (state_d == S_DATA);
    busy_d      = (state_d != S_IDLE);
    msg_done_d  = (state_d == S_DONE);
    dat_valid_d = emit;
    dat_lsb_d   = word;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      widx_q      <= '0;
      bytes_q     <= '0;
      s_ready_q   <= 1'b0;
      dat_valid_q <= 1'b0;
      dat_lsb_q   <= '0;
      busy_q      <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      widx_q      <= widx_d;
      bytes_q     <= bytes_d;
      s_ready_q   <= s_ready_d;
      dat_valid_q <= dat_valid_d;
      dat_lsb_q   <= dat_lsb_d;
      busy_q      <= busy_d;
      msg_done_q  <= msg_done_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign dat_valid_o = dat_valid_q;
  assign dat_lsb_o   = dat_lsb_q;
  assign busy_o      = busy_q;
  assign msg_done_o  = msg_done_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: bench for sha256_msg_padder.
// A stand-in for the core collects chunks and answers each one with a delayed finish pulse.
// Each message is checked against a byte-level padding model and against the
// constants in the vector table.
module tb_sha256_msg_padder;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [2:0]  s_nbytes;
  logic        dat_valid_o;
  logic [31:0] dat_lsb_o;
  logic        core_finish_i;
  logic        busy_o;
  logic        msg_done_o;

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_nbytes(s_nbytes),
    .dat_valid_o(dat_valid_o), .dat_lsb_o(dat_lsb_o),
    .core_finish_i(core_finish_i), .busy_o(busy_o), .msg_done_o(msg_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  msg_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          done_cnt;
  int          prot_err;
  int          fin_delay;

  typedef struct {
    int          len;
    int          gap_max;
    int          fin_dly;
    bit          abc;
    int          exp_words;
    logic [31:0] exp_last;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Core stand-in: counts words into chunks, flags words or s_ready during the
  // pending window, and returns a finish pulse fin_delay cycles after each chunk.
  initial begin : core_model
    int cnt;
    int dly;
    bit pending;
    cnt = 0; dly = 0; pending = 0;
    core_finish_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0; pending = 0; core_finish_i = 1'b0;
      end else begin
        core_finish_i = 1'b0;
        if (dat_valid_o) begin
          if (pending) prot_err++;
          got_q.push_back(dat_lsb_o);
          cnt++;
          if (cnt == 16) begin
            cnt = 0; pending = 1; dly = fin_delay;
          end
        end else if (pending) begin
          if (s_ready) prot_err++;
          if (dly == 0) begin
            core_finish_i = 1'b1;
            pending = 0;
          end else begin
            dly--;
          end
        end
        if (msg_done_o) done_cnt++;
      end
    end
  end

  // Padding model: append 0x80, zero-fill to 56 mod 64, then the 64-bit big-endian
  // bit count; pack 4 bytes per word with the first byte in [7:0]
  task automatic build_expected();
    logic [7:0]  p[$];
    logic [63:0] bl;
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bl = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
    exp_q.delete();
    for (int i = 0; i < p.size(); i += 4) exp_q.push_back({p[i+3], p[i+2], p[i+1], p[i]});
  endtask

  task automatic drive_word(input logic [31:0] d, input logic last, input logic [2:0] nb,
                            input int gap_max);
    int g;
    int bound;
    g = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
    repeat (g) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = last; s_nbytes = nb;
    bound = 0;
    while (!s_ready && bound < 5000) begin
      @(negedge clk);
      bound++;
    end
    if (!s_ready) begin
      $display("FAIL s_ready_timeout: got 0 expected 1");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "handshake timeout");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0; s_nbytes = 3'd0;
  endtask

  task automatic send_msg(input int gap_max);
    int n;
    int nw;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d;
      int nb;
      bit last;
      d    = $urandom;
      last = (w == nw - 1);
      nb   = last ? (n - 4 * w) : 4;
      for (int b = 0; b < nb; b++) d[b*8 +: 8] = msg_q[4*w + b];
      drive_word(d, last, 3'(nb), gap_max);
    end
  endtask

  // Send msg_q, wait for msg_done, then check the words and handshake behaviour
  task automatic run_msg(input string tag, input int gap_max, input int dly);
    int bound;
    int ng;
    fin_delay = dly;
    got_q.delete();
    done_cnt = 0;
    prot_err = 0;
    build_expected();
    send_msg(gap_max);
    bound = 0;
    while (done_cnt == 0 && bound < 6000) begin
      @(negedge clk);
      bound++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_done"}, 64'(done_cnt), 64'd1);
    check({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    ng = got_q.size();
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), (i < ng) ? 64'(got_q[i]) : 64'hdead_beef_dead_beef,
            64'(exp_q[i]));
    check({tag, "_protocol"}, 64'(prot_err), 64'd0);
    check({tag, "_idle"}, {62'd0, busy_o, s_ready}, 64'd1);
  endtask

  initial begin
    tbl[0]  = '{len:0,   gap_max:0, fin_dly:2,  abc:0, exp_words:16, exp_last:32'h0000_0000};
    tbl[1]  = '{len:3,   gap_max:0, fin_dly:3,  abc:1, exp_words:16, exp_last:32'h1800_0000};
    tbl[2]  = '{len:55,  gap_max:1, fin_dly:4,  abc:0, exp_words:16, exp_last:32'hB801_0000};
    tbl[3]  = '{len:56,  gap_max:0, fin_dly:5,  abc:0, exp_words:32, exp_last:32'hC001_0000};
    tbl[4]  = '{len:64,  gap_max:3, fin_dly:20, abc:0, exp_words:32, exp_last:32'h0002_0000};
    tbl[5]  = '{len:1,   gap_max:0, fin_dly:0,  abc:0, exp_words:16, exp_last:32'h0800_0000};
    tbl[6]  = '{len:4,   gap_max:2, fin_dly:1,  abc:0, exp_words:16, exp_last:32'h2000_0000};
    tbl[7]  = '{len:52,  gap_max:0, fin_dly:3,  abc:0, exp_words:16, exp_last:32'hA001_0000};
    tbl[8]  = '{len:60,  gap_max:1, fin_dly:6,  abc:0, exp_words:32, exp_last:32'hE001_0000};
    tbl[9]  = '{len:63,  gap_max:0, fin_dly:2,  abc:0, exp_words:32, exp_last:32'hF801_0000};
    tbl[10] = '{len:119, gap_max:2, fin_dly:4,  abc:0, exp_words:32, exp_last:32'hB803_0000};
    tbl[11] = '{len:120, gap_max:0, fin_dly:7,  abc:0, exp_words:48, exp_last:32'hC003_0000};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = 3'd0;
    fin_delay = 0; done_cnt = 0; prot_err = 0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_dat_valid", 64'(dat_valid_o), 64'd0);
    check("rst_dat_lsb", 64'(dat_lsb_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_msg_done", 64'(msg_done_o), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_s_ready", 64'(s_ready), 64'd1);

    // Table-driven directed messages
    for (int t = 0; t < 12; t++) begin
      msg_q.delete();
      if (tbl[t].abc) begin
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
      end else begin
        for (int i = 0; i < tbl[t].len; i++) msg_q.push_back(8'($urandom));
      end
      run_msg($sformatf("vec%0d", t), tbl[t].gap_max, tbl[t].fin_dly);
      check($sformatf("vec%0d_tbl_nwords", t), 64'(got_q.size()), 64'(tbl[t].exp_words));
      if (got_q.size() > 0)
        check($sformatf("vec%0d_tbl_last", t), 64'(got_q[got_q.size()-1]), 64'(tbl[t].exp_last));
      if (tbl[t].abc && got_q.size() > 0)
        check("abc_w0", 64'(got_q[0]), 64'h8063_6261);
      if (tbl[t].len == 0 && got_q.size() > 0)
        check("empty_w0", 64'(got_q[0]), 64'h0000_0080);
      if (tbl[t].len == 64 && got_q.size() > 16)
        check("len64_c2w0", 64'(got_q[16]), 64'h0000_0080);
    end

    // Reset in the middle of DATA after 7 words, then a clean "abc" message
    got_q.delete();
    for (int w = 0; w < 7; w++) drive_word($urandom, 1'b0, 3'd0, 0);
    #2;
    check("mid_busy", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_s_ready", 64'(s_ready), 64'd0);
    check("mid_rst_dat_valid", 64'(dat_valid_o), 64'd0);
    check("mid_rst_dat_lsb", 64'(dat_lsb_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_msg_done", 64'(msg_done_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    run_msg("post_rst_abc", 0, 3);
    begin
      logic [31:0] abc_chunk[16];
      for (int i = 0; i < 16; i++) abc_chunk[i] = 32'h0;
      abc_chunk[0]  = 32'h8063_6261;
      abc_chunk[15] = 32'h1800_0000;
      for (int i = 0; i < 16; i++)
        check($sformatf("post_rst_abc_const_w%0d", i),
              (i < got_q.size()) ? 64'(got_q[i]) : 64'hdead_beef_dead_beef, 64'(abc_chunk[i]));
    end

    // Randomised messages against the padding model
    for (int r = 0; r < 20; r++) begin
      int len;
      len = int'($urandom_range(0, 200));
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d_len%0d", r, len), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 10)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
